// File: rtl/safecrack_pkg.sv
// Shared types and helpers for the safecrack lock.
//   state_t       : one-hot FSM state encoding (ENTRY, ERROR, SUCCESS, LOCKOUT)
//   ms_to_cycles(): milliseconds to clock cycles for a given clock frequency
//   thermometer() : n lowest bits set, returned in a wide vector for callers to cast down
package safecrack_pkg;

  typedef enum logic [3:0] {
    StEntry   = 4'b0001,
    StError   = 4'b0010,
    StSuccess = 4'b0100,
    StLockout = 4'b1000
  } state_t;

  localparam int unsigned ThermoW = 64;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [ThermoW-1:0] thermometer(input int unsigned n);
    logic [ThermoW-1:0] t;
    t = '0;
    for (int i = 0; i < ThermoW; i++) begin
      if ($unsigned(i) < n) t[i] = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Converts raw active-low buttons to active-high and flags press (rising) edges.
//   clk      : system clock
//   rst      : synchronous active-high reset; clears history so a held button
//              reports an edge on the first cycle after reset
//   btn_n    : raw buttons, active-low, already synchronised
//   btn_edge : one-cycle high on each newly pressed button
module btn_edge_detect #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] btn_n,
  output logic [W-1:0] btn_edge
);

  logic [W-1:0] pos;
  logic [W-1:0] btn_prev_d, btn_prev_q;

  assign pos = ~btn_n;

  always_comb begin
    btn_prev_d = pos;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q <= '0;
    end else begin
      btn_prev_q <= btn_prev_d;
    end
  end

  assign btn_edge = pos & ~btn_prev_q;

endmodule

// File: rtl/safecrack_lock_fsm.sv
// N-button code lock with programmable code, inactivity timeout and failure lockout.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   btn        : raw active-low buttons
//   code_in    : replacement code, digit i at [i*BW +: BW]
//   prog_en    : rising edge while in SUCCESS writes code_in into the code register
//   prog_ack   : one-cycle pulse when the code register is written
//   led_green  : entry progress (thermometer) / all ones on success
//   led_red    : failure count (thermometer) in ERROR / all ones in LOCKOUT
//   locked_out : high while in LOCKOUT
//   fail_cnt   : consecutive failure count
module safecrack_lock_fsm
  import safecrack_pkg::*;
#(
  parameter int unsigned     NUM_BTN         = 4,
  parameter int unsigned     CODE_LEN        = 4,
  parameter int unsigned     LED_W           = 10,
  parameter int unsigned     CLK_HZ          = 50_000_000,
  parameter int unsigned     ERROR_MS        = 3000,
  parameter int unsigned     SUCCESS_MS      = 5000,
  parameter int unsigned     LOCKOUT_MS      = 10000,
  parameter int unsigned     IDLE_TIMEOUT_MS = 8000,
  parameter int unsigned     MAX_FAILS       = 3,
  parameter bit              IMMEDIATE_ERR   = 1'b1,
  parameter longint unsigned DEFAULT_CODE    = 64'h1B
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_BTN-1:0]                    btn,
  input  logic [CODE_LEN*$clog2(NUM_BTN)-1:0]   code_in,
  input  logic                                  prog_en,
  output logic                                  prog_ack,
  output logic [LED_W-1:0]                      led_green,
  output logic [LED_W-1:0]                      led_red,
  output logic                                  locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0]        fail_cnt
);

  localparam int unsigned BW    = $clog2(NUM_BTN);
  localparam int unsigned CodeW = CODE_LEN * BW;
  localparam int unsigned IdxW  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned FcW   = $clog2(MAX_FAILS + 1);

  localparam int unsigned ErrCycI  = ms_to_cycles(CLK_HZ, ERROR_MS);
  localparam int unsigned SuccCycI = ms_to_cycles(CLK_HZ, SUCCESS_MS);
  localparam int unsigned LockCycI = ms_to_cycles(CLK_HZ, LOCKOUT_MS);
  localparam int unsigned IdleCycI = ms_to_cycles(CLK_HZ, IDLE_TIMEOUT_MS);
  localparam int unsigned MaxCyc   = max_u(max_u(ErrCycI, SuccCycI), max_u(LockCycI, IdleCycI));
  localparam int unsigned TimerW   = (MaxCyc < 1) ? 1 : $clog2(MaxCyc + 1);

  localparam logic [TimerW-1:0] ErrCyc  = TimerW'(ErrCycI);
  localparam logic [TimerW-1:0] SuccCyc = TimerW'(SuccCycI);
  localparam logic [TimerW-1:0] LockCyc = TimerW'(LockCycI);
  localparam logic [TimerW-1:0] IdleCyc = TimerW'(IdleCycI);
  localparam bit                IdleEn  = (IDLE_TIMEOUT_MS != 0);

  localparam logic [IdxW-1:0]  LastIdx    = IdxW'(CODE_LEN - 1);
  localparam logic [FcW-1:0]   MaxFailsM1 = FcW'(MAX_FAILS - 1);
  localparam logic [CodeW-1:0] ResetCode  = CodeW'(DEFAULT_CODE);

  if (CODE_LEN + 1 > LED_W) begin : g_chk_code_len
    $error("CODE_LEN+1 must not exceed LED_W");
  end
  if (MAX_FAILS > LED_W || MAX_FAILS < 1) begin : g_chk_max_fails
    $error("MAX_FAILS must be within 1..LED_W");
  end
  if (NUM_BTN < 2) begin : g_chk_num_btn
    $error("NUM_BTN must be at least 2");
  end

  state_t            state_d, state_q;
  logic [IdxW-1:0]   digit_idx_d, digit_idx_q;
  logic              err_flag_d, err_flag_q;
  logic [FcW-1:0]    fail_cnt_d, fail_cnt_q;
  logic [TimerW-1:0] timer_d, timer_q;
  logic [CodeW-1:0]  code_reg_d, code_reg_q;
  logic              prog_prev_d, prog_prev_q;
  logic              prog_ack_d, prog_ack_q;

  logic [NUM_BTN-1:0] btn_edge;
  logic               digit_evt;
  logic               wrong;
  logic [BW-1:0]      btn_idx;
  logic [BW-1:0]      exp_digit;
  logic               go_fail;

  btn_edge_detect #(
    .W (NUM_BTN)
  ) u_btn_edge (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn),
    .btn_edge (btn_edge)
  );

  // Digit decode: anything but a single edge on the expected button is wrong.
  always_comb begin
    btn_idx = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn_edge[i]) btn_idx = BW'(i);
    end
    exp_digit = code_reg_q[32'(digit_idx_q)*BW +: BW];
    digit_evt = |btn_edge;
    wrong     = !($onehot(btn_edge) && (btn_idx == exp_digit));
  end

  always_comb begin
    state_d     = state_q;
    digit_idx_d = digit_idx_q;
    err_flag_d  = err_flag_q;
    fail_cnt_d  = fail_cnt_q;
    timer_d     = timer_q;
    code_reg_d  = code_reg_q;
    prog_prev_d = prog_en;
    prog_ack_d  = 1'b0;
    go_fail     = 1'b0;

    unique case (state_q)
      StEntry: begin
        if (digit_evt) begin
          timer_d = IdleCyc;
          if ((IMMEDIATE_ERR && wrong) || (digit_idx_q == LastIdx)) begin
            digit_idx_d = '0;
            err_flag_d  = 1'b0;
            if (err_flag_q || wrong) begin
              go_fail = 1'b1;
            end else begin
              state_d    = StSuccess;
              timer_d    = SuccCyc;
              fail_cnt_d = '0;
            end
          end else begin
            digit_idx_d = digit_idx_q + 1'b1;
            if (wrong) err_flag_d = 1'b1;
          end
        end else if (IdleEn && (digit_idx_q != '0)) begin
          // Abandoned entry: start over without counting a failure.
          if (timer_q == '0) begin
            digit_idx_d = '0;
            err_flag_d  = 1'b0;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end

      StError: begin
        if (timer_q == '0) begin
          state_d     = StEntry;
          digit_idx_d = '0;
          err_flag_d  = 1'b0;
          timer_d     = IdleCyc;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      StSuccess: begin
        if (prog_en && !prog_prev_q) begin
          code_reg_d = code_in;
          prog_ack_d = 1'b1;
        end
        if (timer_q == '0) begin
          state_d     = StEntry;
          digit_idx_d = '0;
          err_flag_d  = 1'b0;
          timer_d     = IdleCyc;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      StLockout: begin
        if (timer_q == '0) begin
          state_d     = StEntry;
          digit_idx_d = '0;
          err_flag_d  = 1'b0;
          fail_cnt_d  = '0;
          timer_d     = IdleCyc;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d     = StEntry;
        digit_idx_d = '0;
        err_flag_d  = 1'b0;
        timer_d     = '0;
      end
    endcase

    if (go_fail) begin
      if (fail_cnt_q == MaxFailsM1) begin
        state_d = StLockout;
        timer_d = LockCyc;
      end else begin
        state_d    = StError;
        timer_d    = ErrCyc;
        fail_cnt_d = fail_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEntry;
      digit_idx_q <= '0;
      err_flag_q  <= 1'b0;
      fail_cnt_q  <= '0;
      timer_q     <= '0;
      code_reg_q  <= ResetCode;
      prog_prev_q <= 1'b0;
      prog_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_idx_q <= digit_idx_d;
      err_flag_q  <= err_flag_d;
      fail_cnt_q  <= fail_cnt_d;
      timer_q     <= timer_d;
      code_reg_q  <= code_reg_d;
      prog_prev_q <= prog_prev_d;
      prog_ack_q  <= prog_ack_d;
    end
  end

  always_comb begin
    led_green  = '0;
    led_red    = '0;
    locked_out = 1'b0;
    unique case (state_q)
      StEntry:   led_green = LED_W'(thermometer(32'(digit_idx_q) + 32'd1));
      StError:   led_red   = LED_W'(thermometer(32'(fail_cnt_q)));
      StSuccess: led_green = '1;
      StLockout: begin
        led_red    = '1;
        locked_out = 1'b1;
      end
      default: begin
        led_green = '0;
      end
    endcase
  end

  assign prog_ack = prog_ack_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: doc/safecrack_lock_fsm.md
Name: safecrack_lock_fsm

Overview:
Parametrised successor to the board's three-button safecrack lock. It supports an N-button keypad, a CODE_LEN-digit code held in a programmable register, and selectable immediate or deferred error reporting. It also adds an entry inactivity timeout and a lockout after repeated failures. It drives the same green/red LED banks and sits directly behind the raw active-low board buttons.

Parameters:
NUM_BTN, 4, number of buttons (>=2)
CODE_LEN, 4, digits per code (CODE_LEN+1 <= LED_W)
LED_W, 10, width of each LED bank
CLK_HZ, 50_000_000, clock frequency
ERROR_MS, 3000, ERROR display time
SUCCESS_MS, 5000, SUCCESS display time
LOCKOUT_MS, 10000, LOCKOUT display time
IDLE_TIMEOUT_MS, 8000, entry inactivity timeout; 0 disables it
MAX_FAILS, 3, consecutive failures that trigger LOCKOUT (1..LED_W)
IMMEDIATE_ERR, 1, 1 = error on first wrong digit; 0 = error only after CODE_LEN digits
DEFAULT_CODE, 0x1B, code loaded at reset; digit i at bits [i*BW +: BW], BW=$clog2(NUM_BTN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn  in  NUM_BTN  raw buttons, active-low, already synchronised
code_in  in  CODE_LEN*BW  new code value for programming
prog_en  in  1  programming request, honoured only in SUCCESS
prog_ack  out  1  one-cycle pulse when the code register is written
led_green  out  LED_W  progress/success indication
led_red  out  LED_W  failure/lockout indication
locked_out  out  1  high while in LOCKOUT
fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failure count

Behaviour:
- Reset (clk edge with rst=1):
  - state=ENTRY, digit_idx=0, err_flag=0, fail_cnt=0, timer=0.
  - code_reg=DEFAULT_CODE, btn_prev=0 (all released), prog_ack=0.
- Edge detect:
  - pos=~btn; edge=pos & ~btn_prev; btn_prev<=pos every cycle.
  - A button held through reset produces an edge on the first cycle after reset.
- Digit event: any edge bit set. Valid digit = exactly one edge bit set AND its index equals code_reg digit[digit_idx]. Multiple simultaneous edges are a wrong digit.
- Timer: single down-counter sized for the largest of the *_MS values in cycles (CLK_HZ/1000*MS). It is loaded on state entry and decrements to 0.
- States:
  - ENTRY:
    - On a digit event: a wrong digit sets err_flag; digit_idx advances; the timer reloads to IDLE_TIMEOUT.
    - IMMEDIATE_ERR=1 and wrong digit -> FAIL path at once.
    - On the last digit (digit_idx==CODE_LEN-1): err_flag|wrong -> FAIL path; otherwise -> SUCCESS.
    - Timeout: timer reaches 0 with digit_idx>0 and IDLE_TIMEOUT_MS!=0. Effect: digit_idx=0, err_flag=0; fail_cnt is unchanged. The timer does not run while digit_idx==0.
  - FAIL path: fail_cnt+1 == MAX_FAILS -> LOCKOUT (timer=LOCKOUT); otherwise fail_cnt++ and -> ERROR (timer=ERROR).
  - ERROR: button edges are ignored. At timer==0 -> ENTRY, with digit_idx=0 and err_flag=0.
  - SUCCESS:
    - fail_cnt=0 on entry.
    - A rising edge of prog_en (sampled, prev reset 0) writes code_reg<=code_in and pulses prog_ack in the next cycle.
    - At timer==0 -> ENTRY.
  - LOCKOUT: all buttons are ignored. At timer==0 -> ENTRY with fail_cnt=0.
- Latency: the state changes on the clock edge after the cycle in which the edge is detected.
- Dwell: each timed state lasts exactly MS*CLK_HZ/1000 + 1 cycles.
- Outputs (registered-state decode, combinational):
  - ENTRY: green = thermometer of digit_idx+1 LSBs; red = 0.
  - ERROR: green = 0; red = thermometer of fail_cnt.
  - SUCCESS: green = all ones; red = 0.
  - LOCKOUT: green = 0; red = all ones; locked_out = 1.
- Reset mid-operation: returns to ENTRY and restores DEFAULT_CODE, even if the code had been reprogrammed.
- An illegal state encoding -> ENTRY.
- Elaboration assertions: CODE_LEN+1<=LED_W, MAX_FAILS<=LED_W, NUM_BTN>=2.

Decomposition:
- Package safecrack_pkg:
  - state_t (one-hot: ENTRY, ERROR, SUCCESS, LOCKOUT)
  - ms_to_cycles() function
  - thermometer() function
- Sub-module btn_edge_detect: parameter W; ports clk, rst, btn_n, edge. Provides the inversion plus rising-edge detect, and is reused by other panel blocks.

Test Plan:
All tests use CLK_HZ=1000 (1 ms = 1 cycle), ERROR_MS=3, SUCCESS_MS=5, LOCKOUT_MS=7, IDLE_TIMEOUT_MS=4, MAX_FAILS=3.
1. Press 3,2,1,0 (DEFAULT_CODE 0x1B) -> green 1,3,7,15 then 0x3FF for 6 cycles -> ENTRY with green=1 and fail_cnt=0.
2. IMMEDIATE_ERR=1: press 3 then 0 -> ERROR after the second press; red=0x001 for 4 cycles; fail_cnt=1; then green=1.
3. IMMEDIATE_ERR=0: press 3,0,1,0 -> green reaches 15 with no early error; after the fourth press -> ERROR.
4. Three consecutive failures -> third goes to LOCKOUT: red=0x3FF, locked_out=1 for 8 cycles, presses ignored; then fail_cnt=0.
5. In SUCCESS, pulse prog_en with code_in=0x00 -> prog_ack one cycle. Afterwards 0,0,0,0 succeeds and 3,2,1,0 fails. Assert rst -> 3,2,1,0 succeeds again.
6. Press 3, idle 5 cycles -> digit_idx back to 0 (green=1) with fail_cnt unchanged. Buttons 0 and 1 pressed in the same cycle at idx 0 -> treated as a wrong digit.
